// File: rtl/cpu_pkg.sv
// Shared CPU-side definitions: memory arbiter state encodings, port ids, default bus widths.
package cpu_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_OWN_C = 2'd1,
      ARB_OWN_L = 2'd2
   } arb_state_t;

   localparam logic PORT_C = 1'b0;
   localparam logic PORT_L = 1'b1;

   localparam int CPU_AW = 8;
   localparam int CPU_DW = 8;

endpackage

// File: rtl/arb_rdata_return.sv
// Read-return path: registers which port issued a read and steers mem_rdata back to it one
// cycle later; each port's rdata holds its last returned value between reads.
module arb_rdata_return
   import cpu_pkg::*;
#(
   parameter int DW = CPU_DW
) (
   input  logic                 clk,
   input  logic                 i_rst_n,
   input  logic [1:0]           i_rd_issue,
   input  logic [DW-1:0]        i_mem_rdata,
   output logic [1:0]           o_rvalid,
   output logic [1:0][DW-1:0]   o_rdata
);

   logic [1:0]          r_tag;
   logic [1:0][DW-1:0]  r_hold;

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tag  <= '0;
         r_hold <= '0;
      end else begin
         r_tag <= i_rd_issue;
         for (int p = 0; p < 2; p++)
            if (r_tag[p]) r_hold[p] <= i_mem_rdata;
      end
   end

   assign o_rvalid = r_tag;

   for (genvar p = 0; p < 2; p++) begin : g_port
      assign o_rdata[p] = r_tag[p] ? i_mem_rdata : r_hold[p];
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port (CPU / loader) arbiter for a single-port 1-cycle-latency memory, with burst-limited
// hand-over. Define MEM_BUS_ARB_RR_EN for round-robin tie-break from IDLE; default is CPU priority.
module mem_bus_arbiter
   import cpu_pkg::*;
#(
   parameter int AW        = CPU_AW,
   parameter int DW        = CPU_DW,
   parameter int MAX_BURST = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          c_req,
   input  logic          c_we,
   input  logic [AW-1:0] c_addr,
   input  logic [DW-1:0] c_wdata,
   output logic          c_gnt,
   output logic          c_rvalid,
   output logic [DW-1:0] c_rdata,
   input  logic          l_req,
   input  logic          l_we,
   input  logic [AW-1:0] l_addr,
   input  logic [DW-1:0] l_wdata,
   output logic          l_gnt,
   output logic          l_rvalid,
   output logic [DW-1:0] l_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   localparam int BCW = $clog2(MAX_BURST + 1);

   arb_state_t           r_state;
   logic [BCW-1:0]       r_burst;
   logic [AW-1:0]        r_addr_hold;
   logic [DW-1:0]        r_wdata_hold;

   logic w_idle, w_own_c, w_own_l, w_own_port;
   logic w_own_req, w_oth_req, w_at_limit;
   logic w_release, w_enter, w_enter_port, w_idle_pick, w_tie_pick;
   logic w_gnt;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_wdata;
   logic [1:0]           w_rvalid;
   logic [1:0][DW-1:0]   w_rdata;

   assign w_idle     = (r_state == ARB_IDLE);
   assign w_own_c    = (r_state == ARB_OWN_C);
   assign w_own_l    = (r_state == ARB_OWN_L);
   assign w_own_port = w_own_l ? PORT_L : PORT_C;
   assign w_own_req  = w_own_c ? c_req : l_req;
   assign w_oth_req  = w_own_c ? l_req : c_req;
   assign w_at_limit = (r_burst >= BCW'(MAX_BURST - 1));

   assign c_gnt   = w_own_c & c_req;
   assign l_gnt   = w_own_l & l_req;
   assign w_gnt   = c_gnt | l_gnt;
   assign w_addr  = l_gnt ? l_addr  : c_addr;
   assign w_wdata = l_gnt ? l_wdata : c_wdata;

   assign mem_addr  = w_gnt ? w_addr  : r_addr_hold;
   assign mem_wdata = w_gnt ? w_wdata : r_wdata_hold;
   assign mem_we    = (c_gnt & c_we) | (l_gnt & l_we);
   assign busy      = ~w_idle;

`ifdef MEM_BUS_ARB_RR_EN
   logic r_last_owner;
   assign w_tie_pick = ~r_last_owner;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       r_last_owner <= PORT_L;
      else if (w_enter) r_last_owner <= w_enter_port;
   end
`else
   assign w_tie_pick = PORT_C;
`endif

   assign w_idle_pick  = (c_req & l_req) ? w_tie_pick : (l_req ? PORT_L : PORT_C);
   // Owner lets go when it stops requesting, or after its last allowed grant if the other waits.
   assign w_release    = (w_own_c | w_own_l) & (~w_own_req | (w_oth_req & w_at_limit));
   assign w_enter      = (w_idle & (c_req | l_req)) | (w_release & w_oth_req);
   assign w_enter_port = w_idle ? w_idle_pick : ~w_own_port;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ARB_IDLE;
         r_burst      <= '0;
         r_addr_hold  <= '0;
         r_wdata_hold <= '0;
      end else begin
         if (w_gnt) begin
            r_addr_hold  <= w_addr;
            r_wdata_hold <= w_wdata;
         end
         if (w_enter) begin
            r_state <= (w_enter_port == PORT_C) ? ARB_OWN_C : ARB_OWN_L;
            r_burst <= '0;
         end else if (w_release || !(w_own_c || w_own_l)) begin
            r_state <= ARB_IDLE;
            r_burst <= '0;
         end else if (r_burst != BCW'(MAX_BURST)) begin
            r_burst <= r_burst + 1'b1;
         end
      end
   end

   arb_rdata_return #(.DW(DW)) u_rdata_return (
      .clk         (clk),
      .i_rst_n     (reset),
      .i_rd_issue  ({l_gnt & ~l_we, c_gnt & ~c_we}),
      .i_mem_rdata (mem_rdata),
      .o_rvalid    (w_rvalid),
      .o_rdata     (w_rdata)
   );

   assign c_rvalid = w_rvalid[PORT_C];
   assign l_rvalid = w_rvalid[PORT_L];
   assign c_rdata  = w_rdata[PORT_C];
   assign l_rdata  = w_rdata[PORT_L];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized traffic against a
// transaction-level ownership/memory model.
module tb_mem_bus_arbiter;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int MB = 4;
`ifdef MEM_BUS_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          c_req, c_we, l_req, l_we;
   logic [AW-1:0] c_addr, l_addr;
   logic [DW-1:0] c_wdata, l_wdata;
   logic          c_gnt, c_rvalid, l_gnt, l_rvalid;
   logic [DW-1:0] c_rdata, l_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_we, busy;

   logic          fill_en;
   logic [AW-1:0] fill_a;
   logic [DW-1:0] fill_d;
   logic [DW-1:0] mem     [256];
   logic [DW-1:0] ref_mem [256];

   int nvec = 0;
   int nerr = 0;

   // transaction model: owner 0=none 1=C 2=L, grants in current tenure, last owner
   int            m_own, m_ten, m_last;
   logic [AW-1:0] m_haddr;
   logic [DW-1:0] m_hwd, m_pd_c, m_pd_l, m_hold_c, m_hold_l;
   logic          m_pc, m_pl;

   mem_bus_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (fill_en)     mem[fill_a]   <= fill_d;
      else if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic idle(input int n);
      c_req = 1'b0; l_req = 1'b0; c_we = 1'b0; l_we = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      @(negedge clk);
      reset = 1'b0; c_req = 1'b1; c_we = 1'b1; c_addr = 8'h00; c_wdata = 8'hEE;
      #1;
      nvec++;
      if ({c_gnt, l_gnt, mem_we, c_rvalid, l_rvalid, busy, mem_addr, mem_wdata, c_rdata, l_rdata} !== 38'd0) begin
         nerr++;
         $display("FAIL reset_state got gnt=%b%b we=%b rv=%b%b busy=%b addr=%h wd=%h exp all 0",
                  c_gnt, l_gnt, mem_we, c_rvalid, l_rvalid, busy, mem_addr, mem_wdata);
      end
      @(negedge clk);
      reset = 1'b1; c_we = 1'b0;
      #1;
      nvec++;
      if ({c_gnt, busy} !== 2'b00) begin
         nerr++; $display("FAIL reset_release_latency got gnt=%b busy=%b exp 0 0", c_gnt, busy);
      end
      @(negedge clk); #1;
      nvec++;
      if ({c_gnt, l_gnt, busy} !== 3'b101) begin
         nerr++; $display("FAIL reset_first_grant got c/l/busy=%b%b%b exp 101", c_gnt, l_gnt, busy);
      end
      @(negedge clk);
      idle(3);
   endtask

   task automatic test_read;
      @(negedge clk);
      c_req = 1'b1; c_we = 1'b0; c_addr = 8'h10;
      #1;
      nvec++;
      if (c_gnt !== 1'b0) begin nerr++; $display("FAIL read_arb_latency got c_gnt=%b exp 0", c_gnt); end
      @(negedge clk); #1;
      nvec++;
      if ({c_gnt, l_gnt, mem_we, mem_addr} !== {3'b100, 8'h10}) begin
         nerr++; $display("FAIL read_issue got gnt=%b%b we=%b addr=%h exp 100 10", c_gnt, l_gnt, mem_we, mem_addr);
      end
      @(negedge clk);
      c_req = 1'b0;
      #1;
      nvec++;
      if ({c_rvalid, l_rvalid, c_rdata} !== {2'b10, 8'hA5}) begin
         nerr++; $display("FAIL read_return got rv=%b%b rdata=%h exp 10 a5", c_rvalid, l_rvalid, c_rdata);
      end
      @(negedge clk); #1;
      nvec++;
      if ({c_rvalid, c_rdata} !== {1'b0, 8'hA5}) begin
         nerr++; $display("FAIL read_hold got rv=%b rdata=%h exp 0 a5", c_rvalid, c_rdata);
      end
      idle(2);
   endtask

   task automatic test_burst;
      int first;
      logic [1:0] e;
      first = RR ? 2 : 1;
      @(negedge clk);
      c_req = 1'b1; c_we = 1'b0; c_addr = 8'h01;
      l_req = 1'b1; l_we = 1'b0; l_addr = 8'h02;
      for (int i = 0; i < 17; i++) begin
         #1;
         if (i == 0) e = 2'b00;
         else e = ((((i - 1) / MB) % 2 == 0) == (first == 1)) ? 2'b10 : 2'b01;
         nvec++;
         if ({c_gnt, l_gnt} !== e) begin
            nerr++; $display("FAIL burst cyc %0d got c/l gnt=%b%b exp %b", i, c_gnt, l_gnt, e);
         end
         @(negedge clk);
      end
      idle(3);
   endtask

   task automatic test_tie;
      @(negedge clk);
      c_req = 1'b1; c_we = 1'b0; c_addr = 8'h05;
      @(negedge clk); @(negedge clk);
      c_req = 1'b0;
      @(negedge clk); @(negedge clk);
      c_req = 1'b1; l_req = 1'b1; l_we = 1'b0; l_addr = 8'h06;
      #1;
      nvec++;
      if ({c_gnt, l_gnt, busy} !== 3'b000) begin
         nerr++; $display("FAIL tie_idle got c/l/busy=%b%b%b exp 000", c_gnt, l_gnt, busy);
      end
      @(negedge clk); #1;
      nvec++;
      if ({c_gnt, l_gnt} !== (RR ? 2'b01 : 2'b10)) begin
         nerr++; $display("FAIL tie_winner got c/l gnt=%b%b exp %b", c_gnt, l_gnt, RR ? 2'b01 : 2'b10);
      end
      @(negedge clk);
      idle(3);
   endtask

   task automatic test_write_stall;
      @(negedge clk);
      l_req = 1'b1; l_we = 1'b1; l_addr = 8'h20; l_wdata = 8'h3C;
      @(negedge clk);
      c_req = 1'b1; c_we = 1'b0; c_addr = 8'h20;
      #1;
      nvec++;
      if ({c_gnt, l_gnt, mem_we, mem_addr, mem_wdata} !== {3'b011, 8'h20, 8'h3C}) begin
         nerr++; $display("FAIL wr_issue got gnt=%b%b we=%b addr=%h wd=%h exp 011 20 3c",
                          c_gnt, l_gnt, mem_we, mem_addr, mem_wdata);
      end
      @(negedge clk);
      l_req = 1'b0; l_we = 1'b0;
      #1;
      nvec++;
      if ({c_gnt, l_gnt, mem_we, l_rvalid, mem_addr, mem_wdata} !== {4'b0000, 8'h20, 8'h3C}) begin
         nerr++; $display("FAIL wr_single got gnt=%b%b we=%b lrv=%b addr=%h wd=%h exp 0000 20 3c",
                          c_gnt, l_gnt, mem_we, l_rvalid, mem_addr, mem_wdata);
      end
      @(negedge clk); #1;
      nvec++;
      if ({c_gnt, l_gnt, mem_we, mem_addr} !== {3'b100, 8'h20}) begin
         nerr++; $display("FAIL wr_handover got gnt=%b%b we=%b addr=%h exp 100 20", c_gnt, l_gnt, mem_we, mem_addr);
      end
      @(negedge clk);
      c_req = 1'b0;
      #1;
      nvec++;
      if ({c_rvalid, c_rdata} !== {1'b1, 8'h3C}) begin
         nerr++; $display("FAIL wr_readback got rv=%b rdata=%h exp 1 3c", c_rvalid, c_rdata);
      end
      ref_mem[8'h20] = 8'h3C;
      idle(2);
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      c_req = 1'b1; c_we = 1'b0; c_addr = 8'h10;
      @(negedge clk); #1;
      nvec++;
      if (c_gnt !== 1'b1) begin nerr++; $display("FAIL rstmid_grant got c_gnt=%b exp 1", c_gnt); end
      @(negedge clk);
      c_req = 1'b0; reset = 1'b0;
      #1;
      nvec++;
      if ({c_rvalid, l_rvalid, busy, c_rdata} !== 11'd0) begin
         nerr++; $display("FAIL rstmid_drop got rv=%b%b busy=%b rdata=%h exp 000 00", c_rvalid, l_rvalid, busy, c_rdata);
      end
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         nvec++;
         if ({c_rvalid, l_rvalid, c_gnt, l_gnt} !== 4'b0000) begin
            nerr++; $display("FAIL rstmid_after cyc %0d got rv=%b%b gnt=%b%b exp 0000", i, c_rvalid, l_rvalid, c_gnt, l_gnt);
         end
         @(negedge clk);
      end
      idle(2);
   endtask

   task automatic test_random(input int n);
      logic e_cg, e_lg, e_we, xr, yr;
      logic g_c, g_l;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd;
      logic [37:0] got, exp;
      @(negedge clk);
      reset = 1'b0; c_req = 1'b0; l_req = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      m_own = 0; m_ten = 0; m_last = 2; m_haddr = '0; m_hwd = '0;
      m_pc = 1'b0; m_pl = 1'b0; m_hold_c = '0; m_hold_l = '0; m_pd_c = '0; m_pd_l = '0;
      g_c = 1'b0; g_l = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (!(c_req && !g_c)) begin
            c_req = ($urandom_range(3) != 0); c_we = $urandom_range(1);
            c_addr = AW'($urandom_range(31)); c_wdata = DW'($urandom);
         end
         if (!(l_req && !g_l)) begin
            l_req = ($urandom_range(3) != 0); l_we = $urandom_range(1);
            l_addr = AW'($urandom_range(31)); l_wdata = DW'($urandom);
         end
         e_cg   = (m_own == 1) && c_req;
         e_lg   = (m_own == 2) && l_req;
         e_we   = (e_cg && c_we) || (e_lg && l_we);
         e_addr = e_cg ? c_addr  : (e_lg ? l_addr  : m_haddr);
         e_wd   = e_cg ? c_wdata : (e_lg ? l_wdata : m_hwd);
         exp = {e_cg, e_lg, e_we, (m_own != 0), m_pc, m_pl, e_addr, e_wd,
                (m_pc ? m_pd_c : m_hold_c), (m_pl ? m_pd_l : m_hold_l)};
         #1;
         got = {c_gnt, l_gnt, mem_we, busy, c_rvalid, l_rvalid, mem_addr, mem_wdata, c_rdata, l_rdata};
         nvec++;
         if (got !== exp) begin
            nerr++; $display("FAIL random cyc %0d got %h exp %h (gnt,we,busy,rv,addr,wd,crd,lrd)", i, got, exp);
         end
         if (m_pc) m_hold_c = m_pd_c;
         if (m_pl) m_hold_l = m_pd_l;
         m_pc = e_cg && !c_we; m_pd_c = ref_mem[c_addr];
         m_pl = e_lg && !l_we; m_pd_l = ref_mem[l_addr];
         if (e_cg && c_we) ref_mem[c_addr] = c_wdata;
         if (e_lg && l_we) ref_mem[l_addr] = l_wdata;
         if (e_cg || e_lg) begin m_haddr = e_addr; m_hwd = e_wd; end
         if (m_own == 0) begin
            if (c_req || l_req) begin
               if (c_req && l_req) m_own = RR ? ((m_last == 1) ? 2 : 1) : 1;
               else m_own = c_req ? 1 : 2;
               m_ten = 0; m_last = m_own;
            end
         end else begin
            xr = (m_own == 1) ? c_req : l_req;
            yr = (m_own == 1) ? l_req : c_req;
            if (xr) m_ten++;
            if (!xr || (yr && m_ten >= MB)) begin
               if (yr) begin m_own = 3 - m_own; m_ten = 0; m_last = m_own; end
               else m_own = 0;
            end
         end
         g_c = e_cg; g_l = e_lg;
      end
      @(negedge clk);
      idle(3);
   endtask

   initial begin
      reset = 1'b0;
      c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
      l_req = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
      fill_en = 1'b1; fill_a = '0; fill_d = '0;
      for (int a = 0; a < 256; a++) begin
         @(negedge clk);
         fill_a = AW'(a);
         fill_d = (a == 8'h10) ? 8'hA5 : DW'(a ^ 8'h5A);
         ref_mem[a] = fill_d;
      end
      @(negedge clk);
      fill_en = 1'b0;
      test_reset();
      test_read();
      test_burst();
      test_tie();
      test_write_stall();
      test_reset_mid();
      test_random(600);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
